multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle control unit for the LEGv8 core. It sequences the shared datapath (instruction register, register file, immediate sign extender, ALU, data memory) through FETCH/DECODE/EXEC/MEM/WB, one state per cycle. Memory states stretch until a ready handshake arrives. It replaces the single-cycle combinational control, so one ALU and one memory port can serve instruction fetch, address generation and branch comparison.

## Interface
- `IMEM_WAIT_MAX`, 16: cycles FETCH waits for `imem_ready` before raising `timeout`.
- `CNTLEN`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `op`  in  11  IR[31:21] from the instruction register.
- `zero`  in  1  ALU zero flag, sampled in EXEC.
- `imem_ready`  in  1  instruction memory data valid.
- `dmem_ready`  in  1  data memory access complete.
- `imem_req`  out  1  instruction fetch request.
- `ir_write`  out  1  latch instruction and old PC.
- `pc_write`  out  1  load PC.
- `pc_src`  out  1  0: PC+4, 1: old_PC + signext.
- `reg2loc`  out  1  read-register-2 select (1: Rt field).
- `alu_src`  out  1  0: register, 1: sign-extended immediate.
- `alu_op`  out  2  00 add, 01 pass-B (CBZ), 10 R-type funct.
- `mem_read`  out  1  data memory read.
- `mem_write`  out  1  data memory write.
- `mem_to_reg`  out  1  writeback source is memory.
- `reg_write`  out  1  register file write enable.
- `illegal`  out  1  one-cycle pulse on undecodable op.
- `timeout`  out  1  sticky, set on fetch timeout.
- `retired`  out  CNTLEN  count of completed instructions.

## Operation
- Opcode classes (decoded from `op`):
  - LDUR `11111000010`
  - STUR `11111000000`
  - CBZ `10110100???`
  - RTYPE: ADD `10001011000`, SUB `11001011000`, AND `10001010000`, ORR `10101010000`
  - anything else is ILLEGAL.
- FETCH:
  - `imem_req`=1.
  - On `imem_ready`: pulse `ir_write`=1 and `pc_write`=1 (`pc_src`=0); go to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
  - When the wait counter reaches IMEM_WAIT_MAX: set `timeout`, go to HALT.
- DECODE:
  - `reg2loc` = 1 for STUR/CBZ, else 0.
  - ILLEGAL: pulse `illegal`, go to FETCH (PC has already advanced; the instruction is skipped, not retired).
  - Any other class: go to EXEC.
- EXEC:
  - LDUR/STUR: `alu_src`=1, `alu_op`=00; go to MEM.
  - RTYPE: `alu_src`=0, `alu_op`=10; go to WB.
  - CBZ: `alu_op`=01, `reg2loc`=1. If `zero`: `pc_write`=1, `pc_src`=1. Retire; go to FETCH.
- MEM:
  - `mem_read` (LDUR) or `mem_write` (STUR) held asserted, with stable ALU controls, until `dmem_ready`.
  - Then LDUR goes to WB; STUR retires and goes to FETCH.
- WB:
  - `reg_write`=1; `mem_to_reg` = 1 for LDUR.
  - Retire; go to FETCH.
- HALT: all outputs inactive; exit only via reset.
- Retiring increments `retired`, which wraps modulo 2^CNTLEN.
- Control outputs not listed for a state are 0.

## Timing
- Reset (async assert, sync release): state=FETCH, wait counter=0, `retired`=0, `timeout`=0, all control outputs 0.
- Outputs are a registered state plus combinational decode of state and `op`. `op` is stable from the cycle after `ir_write`.
- Minimum cycles per class, with zero-wait memories:
  - CBZ: 3
  - STUR: 4
  - RTYPE: 4
  - LDUR: 5
  - ILLEGAL: 2
- Each memory wait cycle adds exactly one cycle.
- `retired` updates on the clock edge that leaves the final state of the instruction.
- `dmem_ready` sampled outside MEM is ignored. `imem_ready` sampled outside FETCH is ignored.
- `imem_ready` on the same cycle the wait counter reaches its limit counts as success; `timeout` is not set.
- Wait counter clears on every entry to FETCH.
- `reset_n` low mid-instruction aborts immediately: no `reg_write`/`mem_write` is asserted after the asynchronous assertion of reset.

## Structure
- `multicycle_pkg`:
  - `state_t` enum (FETCH, DECODE, EXEC, MEM, WB, HALT)
  - `opclass_t` enum (LDUR, STUR, CBZ, RTYPE, ILLEGAL)
  - opcode constants
  - ALU_OP encodings
- Sub-module `opclass_decode`: combinational `op` → `opclass_t` using `casez`; shared with the bench's reference model.

## Test plan
- RTYPE ADD `10001011000`, ready tied high → states FETCH, DECODE, EXEC, WB; `reg_write`=1 in cycle 4; `retired` 0→1.
- LDUR with `dmem_ready` low 2 cycles → 7 cycles total; `mem_read` held 3 cycles; WB has `mem_to_reg`=1.
- CBZ with `zero`=1 → `pc_write`=1 and `pc_src`=1 in EXEC, 3 cycles. Same with `zero`=0 → no second `pc_write`.
- Op `00000000000` → `illegal` pulses in DECODE, `retired` unchanged, next FETCH starts in cycle 3.
- `imem_ready` held low → after 16 FETCH cycles `timeout`=1, HALT, outputs 0. `reset_n` pulse → FETCH, `timeout`=0.
- `reset_n` asserted during STUR MEM → `mem_write` drops the same cycle. `retired` preset to all-ones, then an ADD retires → `retired` wraps to 0.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared types and constants for the LEGv8 multicycle control unit.
package multicycle_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        LDUR,
        STUR,
        CBZ,
        RTYPE,
        ILLEGAL
    } opclass_t;

    // IR[31:21] patterns; '?' bits are don't-care under casez.
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100???;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_PASSB = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

endpackage

// File: rtl/opclass_decode.sv
// Combinational classification of the instruction opcode field.
module opclass_decode
    import multicycle_pkg::*;
(
    input  logic [10:0] op_i,
    output opclass_t    opclass_o
);

    always_comb begin
        opclass_o = ILLEGAL;
        casez (op_i)
            OP_LDUR:                        opclass_o = LDUR;
            OP_STUR:                        opclass_o = STUR;
            OP_CBZ:                         opclass_o = CBZ;
            OP_ADD, OP_SUB, OP_AND, OP_ORR: opclass_o = RTYPE;
            default:                        opclass_o = ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM sequencing the shared LEGv8 datapath through
// FETCH/DECODE/EXEC/MEM/WB, with fetch timeout and a retired-instruction count.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int unsigned IMEM_WAIT_MAX = 16,
    parameter int unsigned CNTLEN        = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [10:0]       op,
    input  logic              zero,
    input  logic              imem_ready,
    input  logic              dmem_ready,
    output logic              imem_req,
    output logic              ir_write,
    output logic              pc_write,
    output logic              pc_src,
    output logic              reg2loc,
    output logic              alu_src,
    output logic [1:0]        alu_op,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic              reg_write,
    output logic              illegal,
    output logic              timeout,
    output logic [CNTLEN-1:0] retired
);

    localparam int unsigned WAITW = $clog2(IMEM_WAIT_MAX + 1);
    localparam logic [WAITW-1:0] WAIT_LAST = WAITW'(IMEM_WAIT_MAX - 1);

    state_t            state_q, state_d;
    logic [WAITW-1:0]  wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic [CNTLEN-1:0] retired_q, retired_d;
    logic              retire;
    opclass_t          opclass;

    opclass_decode u_opclass_decode (
        .op_i      (op),
        .opclass_o (opclass)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= FETCH;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        retired_d = retired_q;
        retire    = 1'b0;
        case (state_q)
            FETCH: begin
                // Ready in the last allowed cycle still wins over the timeout.
                if (imem_ready) begin
                    state_d = DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = HALT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DECODE: state_d = (opclass == ILLEGAL) ? FETCH : EXEC;
            EXEC: begin
                case (opclass)
                    LDUR, STUR: state_d = MEM;
                    RTYPE:      state_d = WB;
                    default: begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEM: begin
                if (dmem_ready) begin
                    if (opclass == LDUR) begin
                        state_d = WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            WB: begin
                retire  = 1'b1;
                state_d = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
        // Clearing whenever outside FETCH guarantees zero on every entry.
        if (state_d != FETCH) wait_d = '0;
        if (retire) retired_d = retired_q + 1'b1;
    end

    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg2loc    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_OP_ADD;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        // Outputs are forced inactive while reset is held, including FETCH's request.
        if (reset_n) begin
            case (state_q)
                FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                DECODE: begin
                    reg2loc = (opclass == STUR) || (opclass == CBZ);
                    illegal = (opclass == ILLEGAL);
                end
                EXEC: begin
                    case (opclass)
                        LDUR, STUR: begin
                            alu_src = 1'b1;
                            alu_op  = ALU_OP_ADD;
                        end
                        RTYPE: alu_op = ALU_OP_RTYPE;
                        CBZ: begin
                            alu_op  = ALU_OP_PASSB;
                            reg2loc = 1'b1;
                            if (zero) begin
                                pc_write = 1'b1;
                                pc_src   = 1'b1;
                            end
                        end
                        default: alu_op = ALU_OP_ADD;
                    endcase
                end
                MEM: begin
                    alu_src   = 1'b1;
                    alu_op    = ALU_OP_ADD;
                    mem_read  = (opclass == LDUR);
                    mem_write = (opclass == STUR);
                end
                WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (opclass == LDUR);
                end
                default: ;
            endcase
        end
    end

    assign timeout = timeout_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl; a 3-bit-counter instance checks wrap.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] op;
    logic        zero, imem_ready, dmem_ready;

    logic        imem_req, ir_write, pc_write, pc_src, reg2loc, alu_src;
    logic [1:0]  alu_op;
    logic        mem_read, mem_write, mem_to_reg, reg_write, illegal, timeout;
    logic [31:0] retired;

    logic        w_imem_req, w_ir_write, w_pc_write, w_pc_src, w_reg2loc, w_alu_src;
    logic [1:0]  w_alu_op;
    logic        w_mem_read, w_mem_write, w_mem_to_reg, w_reg_write, w_illegal, w_timeout;
    logic [2:0]  w_retired;

    int total = 0;
    int bad   = 0;
    int exp_ret = 0;
    logic [27:0] seq[$];

    // Output vector layout: {imem_req,ir_write,pc_write,pc_src}_{reg2loc,alu_src,alu_op}
    //                       _{mem_read,mem_write,mem_to_reg,reg_write}_{illegal,timeout}
    localparam logic [13:0] V_ZERO  = 14'b0000_0000_0000_00;
    localparam logic [13:0] F_WAIT  = 14'b1000_0000_0000_00;
    localparam logic [13:0] F_ACC   = 14'b1110_0000_0000_00;
    localparam logic [13:0] D_PLAIN = 14'b0000_0000_0000_00;
    localparam logic [13:0] D_R2L   = 14'b0000_1000_0000_00;
    localparam logic [13:0] D_ILL   = 14'b0000_0000_0000_10;
    localparam logic [13:0] X_ADDR  = 14'b0000_0100_0000_00;
    localparam logic [13:0] X_RTYPE = 14'b0000_0010_0000_00;
    localparam logic [13:0] X_CBZT  = 14'b0011_1001_0000_00;
    localparam logic [13:0] X_CBZN  = 14'b0000_1001_0000_00;
    localparam logic [13:0] M_RD    = 14'b0000_0100_1000_00;
    localparam logic [13:0] M_WR    = 14'b0000_0100_0100_00;
    localparam logic [13:0] W_REG   = 14'b0000_0000_0001_00;
    localparam logic [13:0] W_LD    = 14'b0000_0000_0011_00;
    localparam logic [13:0] H_TO    = 14'b0000_0000_0000_01;

    localparam logic [10:0] C_LDUR = 11'b11111000010;
    localparam logic [10:0] C_STUR = 11'b11111000000;
    localparam logic [10:0] C_CBZ  = 11'b10110100101;
    localparam logic [10:0] C_ADD  = 11'b10001011000;
    localparam logic [10:0] C_SUB  = 11'b11001011000;
    localparam logic [10:0] C_AND  = 11'b10001010000;
    localparam logic [10:0] C_ORR  = 11'b10101010000;
    localparam logic [10:0] C_BAD  = 11'b00000000000;

    wire [13:0] obs = {imem_req, ir_write, pc_write, pc_src, reg2loc, alu_src, alu_op,
                       mem_read, mem_write, mem_to_reg, reg_write, illegal, timeout};
    wire [13:0] w_obs = {w_imem_req, w_ir_write, w_pc_write, w_pc_src, w_reg2loc, w_alu_src,
                         w_alu_op, w_mem_read, w_mem_write, w_mem_to_reg, w_reg_write,
                         w_illegal, w_timeout};

    always #5 clk = ~clk;

    multicycle_ctrl #(.IMEM_WAIT_MAX(16), .CNTLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg2loc(reg2loc), .alu_src(alu_src), .alu_op(alu_op), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .illegal(illegal), .timeout(timeout), .retired(retired)
    );

    multicycle_ctrl #(.IMEM_WAIT_MAX(16), .CNTLEN(3)) dut_w (
        .clk(clk), .reset_n(reset_n), .op(op), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(w_imem_req), .ir_write(w_ir_write), .pc_write(w_pc_write),
        .pc_src(w_pc_src), .reg2loc(w_reg2loc), .alu_src(w_alu_src), .alu_op(w_alu_op),
        .mem_read(w_mem_read), .mem_write(w_mem_write), .mem_to_reg(w_mem_to_reg),
        .reg_write(w_reg_write), .illegal(w_illegal), .timeout(w_timeout),
        .retired(w_retired)
    );

    function automatic logic [27:0] e(logic [10:0] o, logic im, logic dm, logic z,
                                      logic [13:0] ex);
        return {o, im, dm, z, ex};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; op = C_ADD; zero = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
        @(negedge clk); #1;
        total++;
        if (obs !== V_ZERO) begin bad++; $display("FAIL reset_outputs: got %b want %b", obs, V_ZERO); end
        total++;
        if (retired !== 32'd0 || w_retired !== 3'd0) begin
            bad++; $display("FAIL reset_retired: got %0d/%0d want 0/0", retired, w_retired);
        end
        @(posedge clk); #2 reset_n = 1'b1;
    endtask

    task automatic test_rtype();
        seq.delete();
        seq.push_back(e(C_ADD, 1, 1, 0, F_ACC));
        seq.push_back(e(C_ADD, 1, 1, 0, D_PLAIN));
        seq.push_back(e(C_ADD, 1, 1, 0, X_RTYPE));
        seq.push_back(e(C_ADD, 1, 1, 0, W_REG));
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clk);
            {op, imem_ready, dmem_ready, zero} = seq[i][27:14];
            #1;
            total++;
            if (obs !== seq[i][13:0]) begin bad++; $display("FAIL rtype cyc%0d: got %b want %b", i, obs, seq[i][13:0]); end
            if (i == 0) begin
                total++;
                if (retired !== 32'(exp_ret)) begin bad++; $display("FAIL rtype_retired: got %0d want %0d", retired, exp_ret); end
            end
        end
        exp_ret += 1;
    endtask

    task automatic test_ldur();
        seq.delete();
        seq.push_back(e(C_LDUR, 1, 1, 0, F_ACC));
        seq.push_back(e(C_LDUR, 1, 1, 0, D_PLAIN));
        seq.push_back(e(C_LDUR, 1, 0, 0, X_ADDR));
        seq.push_back(e(C_LDUR, 1, 0, 0, M_RD));
        seq.push_back(e(C_LDUR, 1, 0, 0, M_RD));
        seq.push_back(e(C_LDUR, 1, 1, 0, M_RD));
        seq.push_back(e(C_LDUR, 1, 1, 0, W_LD));
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clk);
            {op, imem_ready, dmem_ready, zero} = seq[i][27:14];
            #1;
            total++;
            if (obs !== seq[i][13:0]) begin bad++; $display("FAIL ldur cyc%0d: got %b want %b", i, obs, seq[i][13:0]); end
            if (i == 0) begin
                total++;
                if (retired !== 32'(exp_ret)) begin bad++; $display("FAIL ldur_retired: got %0d want %0d", retired, exp_ret); end
            end
        end
        exp_ret += 1;
    endtask

    task automatic test_cbz();
        seq.delete();
        seq.push_back(e(C_CBZ, 1, 1, 1, F_ACC));
        seq.push_back(e(C_CBZ, 1, 1, 1, D_R2L));
        seq.push_back(e(C_CBZ, 1, 1, 1, X_CBZT));
        seq.push_back(e(C_CBZ, 1, 1, 0, F_ACC));
        seq.push_back(e(C_CBZ, 1, 1, 1, D_R2L));
        seq.push_back(e(C_CBZ, 1, 1, 0, X_CBZN));
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clk);
            {op, imem_ready, dmem_ready, zero} = seq[i][27:14];
            #1;
            total++;
            if (obs !== seq[i][13:0]) begin bad++; $display("FAIL cbz cyc%0d: got %b want %b", i, obs, seq[i][13:0]); end
            if (i == 0 || i == 3) begin
                total++;
                if (retired !== 32'(exp_ret + i / 3)) begin bad++; $display("FAIL cbz_retired: got %0d want %0d", retired, exp_ret + i / 3); end
            end
        end
        exp_ret += 2;
    endtask

    task automatic test_fetch_limit();
        seq.delete();
        for (int i = 0; i < 15; i++) seq.push_back(e(C_ORR, 0, 1, 0, F_WAIT));
        seq.push_back(e(C_ORR, 1, 1, 0, F_ACC));
        seq.push_back(e(C_ORR, 0, 1, 0, D_PLAIN));
        seq.push_back(e(C_ORR, 0, 1, 0, X_RTYPE));
        seq.push_back(e(C_ORR, 0, 1, 0, W_REG));
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clk);
            {op, imem_ready, dmem_ready, zero} = seq[i][27:14];
            #1;
            total++;
            if (obs !== seq[i][13:0]) begin bad++; $display("FAIL fetch_limit cyc%0d: got %b want %b", i, obs, seq[i][13:0]); end
            if (i == 0) begin
                total++;
                if (retired !== 32'(exp_ret)) begin bad++; $display("FAIL fetch_limit_retired: got %0d want %0d", retired, exp_ret); end
            end
        end
        exp_ret += 1;
    endtask

    task automatic test_stur();
        seq.delete();
        seq.push_back(e(C_STUR, 1, 0, 0, F_ACC));
        seq.push_back(e(C_STUR, 1, 0, 0, D_R2L));
        seq.push_back(e(C_STUR, 1, 0, 0, X_ADDR));
        seq.push_back(e(C_STUR, 1, 1, 0, M_WR));
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clk);
            {op, imem_ready, dmem_ready, zero} = seq[i][27:14];
            #1;
            total++;
            if (obs !== seq[i][13:0]) begin bad++; $display("FAIL stur cyc%0d: got %b want %b", i, obs, seq[i][13:0]); end
            if (i == 0) begin
                total++;
                if (retired !== 32'(exp_ret)) begin bad++; $display("FAIL stur_retired: got %0d want %0d", retired, exp_ret); end
            end
        end
        exp_ret += 1;
    endtask

    task automatic test_illegal();
        seq.delete();
        seq.push_back(e(C_BAD, 1, 1, 0, F_ACC));
        seq.push_back(e(C_BAD, 1, 1, 0, D_ILL));
        seq.push_back(e(C_BAD, 0, 1, 0, F_WAIT));
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clk);
            {op, imem_ready, dmem_ready, zero} = seq[i][27:14];
            #1;
            total++;
            if (obs !== seq[i][13:0]) begin bad++; $display("FAIL illegal cyc%0d: got %b want %b", i, obs, seq[i][13:0]); end
            if (i == 0 || i == 2) begin
                total++;
                if (retired !== 32'(exp_ret)) begin bad++; $display("FAIL illegal_retired: got %0d want %0d", retired, exp_ret); end
            end
        end
    endtask

    task automatic test_stur_reset();
        seq.delete();
        seq.push_back(e(C_STUR, 1, 0, 0, F_ACC));
        seq.push_back(e(C_STUR, 1, 0, 0, D_R2L));
        seq.push_back(e(C_STUR, 1, 0, 0, X_ADDR));
        seq.push_back(e(C_STUR, 1, 0, 0, M_WR));
        seq.push_back(e(C_STUR, 1, 0, 0, M_WR));
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clk);
            {op, imem_ready, dmem_ready, zero} = seq[i][27:14];
            #1;
            total++;
            if (obs !== seq[i][13:0]) begin bad++; $display("FAIL stur_reset cyc%0d: got %b want %b", i, obs, seq[i][13:0]); end
        end
        #1 reset_n = 1'b0;
        #1;
        total++;
        if (obs !== V_ZERO) begin bad++; $display("FAIL stur_abort: got %b want %b", obs, V_ZERO); end
        total++;
        if (retired !== 32'd0) begin bad++; $display("FAIL stur_abort_retired: got %0d want 0", retired); end
        @(posedge clk); #2 reset_n = 1'b1;
        exp_ret = 0;
    endtask

    task automatic test_back_to_back();
        seq.delete();
        seq.push_back(e(C_AND, 1, 0, 0, F_ACC));
        seq.push_back(e(C_AND, 1, 0, 0, D_PLAIN));
        seq.push_back(e(C_AND, 1, 0, 0, X_RTYPE));
        seq.push_back(e(C_AND, 1, 0, 0, W_REG));
        seq.push_back(e(C_SUB, 1, 0, 0, F_ACC));
        seq.push_back(e(C_SUB, 1, 0, 0, D_PLAIN));
        seq.push_back(e(C_SUB, 1, 0, 0, X_RTYPE));
        seq.push_back(e(C_SUB, 1, 0, 0, W_REG));
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clk);
            {op, imem_ready, dmem_ready, zero} = seq[i][27:14];
            #1;
            total++;
            if (obs !== seq[i][13:0]) begin bad++; $display("FAIL back_to_back cyc%0d: got %b want %b", i, obs, seq[i][13:0]); end
            if (i == 0 || i == 4) begin
                total++;
                if (retired !== 32'(exp_ret + i / 4)) begin bad++; $display("FAIL back_to_back_retired: got %0d want %0d", retired, exp_ret + i / 4); end
            end
        end
        exp_ret += 2;
    endtask

    task automatic test_timeout();
        seq.delete();
        for (int i = 0; i < 16; i++) seq.push_back(e(C_ADD, 0, 0, 0, F_WAIT));
        seq.push_back(e(C_ADD, 1, 1, 1, H_TO));
        seq.push_back(e(C_ADD, 1, 1, 1, H_TO));
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clk);
            {op, imem_ready, dmem_ready, zero} = seq[i][27:14];
            #1;
            total++;
            if (obs !== seq[i][13:0]) begin bad++; $display("FAIL timeout cyc%0d: got %b want %b", i, obs, seq[i][13:0]); end
            if (i == 0 || i == 17) begin
                total++;
                if (retired !== 32'(exp_ret)) begin bad++; $display("FAIL timeout_retired: got %0d want %0d", retired, exp_ret); end
            end
        end
        #1 reset_n = 1'b0;
        #1;
        total++;
        if (obs !== V_ZERO) begin bad++; $display("FAIL timeout_clear: got %b want %b", obs, V_ZERO); end
        @(posedge clk); #2 reset_n = 1'b1;
        exp_ret = 0;
        @(negedge clk);
        imem_ready = 1'b0;
        #1;
        total++;
        if (obs !== F_WAIT) begin bad++; $display("FAIL timeout_refetch: got %b want %b", obs, F_WAIT); end
    endtask

    task automatic test_wrap();
        seq.delete();
        seq.push_back(e(C_ADD, 1, 1, 0, F_ACC));
        seq.push_back(e(C_ADD, 1, 1, 0, D_PLAIN));
        seq.push_back(e(C_ADD, 1, 1, 0, X_RTYPE));
        seq.push_back(e(C_ADD, 1, 1, 0, W_REG));
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < seq.size(); i++) begin
                @(negedge clk);
                {op, imem_ready, dmem_ready, zero} = seq[i][27:14];
                #1;
                total++;
                if (w_obs !== seq[i][13:0]) begin bad++; $display("FAIL wrap add%0d cyc%0d: got %b want %b", k, i, w_obs, seq[i][13:0]); end
                if (i == 0) begin
                    total++;
                    if (w_retired !== 3'(k)) begin bad++; $display("FAIL wrap_count add%0d: got %0d want %0d", k, w_retired, k); end
                end
            end
        end
        @(negedge clk);
        imem_ready = 1'b0;
        #1;
        total++;
        if (w_retired !== 3'd0) begin bad++; $display("FAIL wrap_to_zero: got %0d want 0", w_retired); end
        total++;
        if (retired !== 32'd8) begin bad++; $display("FAIL wrap_wide_count: got %0d want 8", retired); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_ldur();
        test_cbz();
        test_fetch_limit();
        test_stur();
        test_illegal();
        test_stur_reset();
        test_back_to_back();
        test_timeout();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
